imem_byte_loader: RTL and testbench

IMEM_BYTE_LOADER -- requirements
Module: imem_byte_loader

---
 rtl/imem_byte_loader_if.sv | 28 ++
 rtl/imem_byte_loader.sv | 125 ++++++++++++
 tb/tb_imem_byte_loader.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/imem_byte_loader_if.sv
// Byte-stream and instruction-memory write bundle for the imem byte loader.
// The master side feeds bytes and session control; the slave side is the loader.
interface imem_byte_loader_if #(
   parameter int ADDR_W = 7
);
   logic              start;
   logic              finish;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_data;
   logic              busy;
   logic              done;
   logic [ADDR_W:0]   word_count;
   logic              overflow;

   modport master (
      output start, finish, byte_valid, byte_data,
      input  byte_ready, mem_we, mem_addr, mem_data, busy, done, word_count, overflow
   );

   modport slave (
      input  start, finish, byte_valid, byte_data,
      output byte_ready, mem_we, mem_addr, mem_data, busy, done, word_count, overflow
   );
endinterface

// File: rtl/imem_byte_loader.sv
// Packs a little-endian byte stream into 32-bit instruction words and writes
// them to consecutive instruction-memory addresses, one session per start pulse.
module imem_byte_loader #(
   parameter int ADDR_W    = 7,
   parameter int MAX_WORDS = 128
) (
   input logic               clk,
   input logic               clr,
   imem_byte_loader_if.slave io_bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);

   logic [1:0]        r_state;
   logic [1:0]        r_idx;
   logic [31:0]       r_data;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_count;
   logic              r_finPend;
   logic              r_overflow;
   logic              r_byteReady;
   logic              r_memWe;
   logic              r_busy;
   logic              r_done;

   logic              w_accept;
   logic [1:0]        w_idxNext;
   logic [ADDR_W:0]   w_countInc;
   logic [1:0]        w_nextState;

   // A byte landing in lane 3 always closes the word; a finish closes it early
   // unless nothing has been packed yet, in which case there is nothing to write.
   always_comb begin
      w_accept    = r_byteReady & io_bus.byte_valid;
      w_idxNext   = r_idx + 2'd1;
      w_countInc  = r_count + (ADDR_W+1)'(1);
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (io_bus.start) w_nextState = LOAD;
         end
         LOAD: begin
            if (w_accept && (r_idx == 2'd3)) begin
               w_nextState = WRITE;
            end else if (io_bus.finish) begin
               if (w_accept || (r_idx != 2'd0)) w_nextState = WRITE;
               else                             w_nextState = DONE;
            end
         end
         WRITE: begin
            if ((w_countInc == MAX_CNT) || r_finPend) w_nextState = DONE;
            else                                       w_nextState = LOAD;
         end
         default: begin
            if (io_bus.start) w_nextState = LOAD;
         end
      endcase
   end

   // Status outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_state     <= IDLE;
         r_idx       <= 2'd0;
         r_data      <= 32'd0;
         r_addr      <= '0;
         r_count     <= '0;
         r_finPend   <= 1'b0;
         r_overflow  <= 1'b0;
         r_byteReady <= 1'b0;
         r_memWe     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_nextState;
         r_byteReady <= (w_nextState == LOAD);
         r_memWe     <= (w_nextState == WRITE);
         r_busy      <= (w_nextState == LOAD) || (w_nextState == WRITE);
         r_done      <= (w_nextState == DONE);
         case (r_state)
            LOAD: begin
               if (w_accept) begin
                  r_data[{r_idx, 3'b000} +: 8] <= io_bus.byte_data;
                  r_idx                        <= w_idxNext;
               end
               if (io_bus.finish && (w_nextState == WRITE)) r_finPend <= 1'b1;
            end
            WRITE: begin
               r_addr    <= r_addr + ADDR_W'(1);
               r_count   <= w_countInc;
               r_data    <= 32'd0;
               r_idx     <= 2'd0;
               r_finPend <= 1'b0;
            end
            default: begin
               if (io_bus.start) begin
                  r_idx      <= 2'd0;
                  r_data     <= 32'd0;
                  r_addr     <= '0;
                  r_count    <= '0;
                  r_finPend  <= 1'b0;
                  r_overflow <= 1'b0;
               end else if ((r_state == DONE) && io_bus.byte_valid && (r_count == MAX_CNT)) begin
                  r_overflow <= 1'b1;
               end
            end
         endcase
      end
   end

   assign io_bus.byte_ready = r_byteReady;
   assign io_bus.mem_we     = r_memWe;
   assign io_bus.mem_addr   = r_addr;
   assign io_bus.mem_data   = r_data;
   assign io_bus.busy       = r_busy;
   assign io_bus.done       = r_done;
   assign io_bus.word_count = r_count;
   assign io_bus.overflow   = r_overflow;

endmodule

// File: tb/tb_imem_byte_loader.sv
// Directed bench for imem_byte_loader: one instance with the default word limit
// and one limited to two words, driven from hand-computed vector tables.
module tb_imem_byte_loader;

   typedef struct packed {
      logic        rdy;
      logic        we;
      logic [6:0]  addr;
      logic [31:0] data;
      logic        busy;
      logic        done;
      logic [7:0]  cnt;
      logic        ovf;
   } outs_t;

   typedef struct {
      logic       st;
      logic       fin;
      logic       v;
      logic [7:0] d;
      outs_t      exp;
   } vec_t;

   logic clk = 1'b0;
   logic clr = 1'b1;
   int   checks = 0;
   int   failures = 0;
   vec_t tabA[$];
   vec_t tabB[$];

   always #5 clk = ~clk;

   imem_byte_loader_if #(.ADDR_W(7)) ifA ();
   imem_byte_loader_if #(.ADDR_W(7)) ifB ();

   imem_byte_loader #(.ADDR_W(7), .MAX_WORDS(128)) dutA (.clk(clk), .clr(clr), .io_bus(ifA));
   imem_byte_loader #(.ADDR_W(7), .MAX_WORDS(2))   dutB (.clk(clk), .clr(clr), .io_bus(ifB));

   function automatic outs_t mkOut(int rdy, int we, int a, logic [31:0] d, int busy, int done, int c, int o);
      outs_t e;
      e.rdy  = (rdy != 0);
      e.we   = (we != 0);
      e.addr = 7'(a);
      e.data = d;
      e.busy = (busy != 0);
      e.done = (done != 0);
      e.cnt  = 8'(c);
      e.ovf  = (o != 0);
      return e;
   endfunction

   function automatic outs_t expLoad(int a, logic [31:0] d, int c);
      return mkOut(1, 0, a, d, 1, 0, c, 0);
   endfunction

   function automatic outs_t expWrite(int a, logic [31:0] d, int c);
      return mkOut(0, 1, a, d, 1, 0, c, 0);
   endfunction

   function automatic outs_t expDone(int a, int c, int o);
      return mkOut(0, 0, a, 32'h0, 0, 1, c, o);
   endfunction

   function automatic vec_t mv(int st, int fin, int v, logic [7:0] d, outs_t e);
      vec_t t;
      t.st  = (st != 0);
      t.fin = (fin != 0);
      t.v   = (v != 0);
      t.d   = d;
      t.exp = e;
      return t;
   endfunction

   task automatic applyStimulus(input int sel, input logic st, input logic fin, input logic v,
                                input logic [7:0] d, input logic c);
      if (sel == 0) begin
         ifA.start = st; ifA.finish = fin; ifA.byte_valid = v; ifA.byte_data = d;
      end else begin
         ifB.start = st; ifB.finish = fin; ifB.byte_valid = v; ifB.byte_data = d;
      end
      clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input int sel, input outs_t e, input string name);
      outs_t act;
      if (sel == 0)
         act = {ifA.byte_ready, ifA.mem_we, ifA.mem_addr, ifA.mem_data,
                ifA.busy, ifA.done, ifA.word_count, ifA.overflow};
      else
         act = {ifB.byte_ready, ifB.mem_we, ifB.mem_addr, ifB.mem_data,
                ifB.busy, ifB.done, ifB.word_count, ifB.overflow};
      checks++;
      if (act !== e) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, e);
      end
   endtask

   initial begin
      outs_t zero;
      zero = mkOut(0, 0, 0, 32'h0, 0, 0, 0, 0);
      ifA.start = 0; ifA.finish = 0; ifA.byte_valid = 0; ifA.byte_data = 8'h00;
      ifB.start = 0; ifB.finish = 0; ifB.byte_valid = 0; ifB.byte_data = 8'h00;

      // Single session word, byte held across WRITE, finish at index 0 and mid-word flushes.
      tabA.push_back(mv(1, 0, 0, 8'h00, expLoad(0, 32'h0, 0)));
      tabA.push_back(mv(0, 0, 1, 8'h13, expLoad(0, 32'h00000013, 0)));
      tabA.push_back(mv(0, 0, 1, 8'h05, expLoad(0, 32'h00000513, 0)));
      tabA.push_back(mv(0, 0, 1, 8'h10, expLoad(0, 32'h00100513, 0)));
      tabA.push_back(mv(0, 0, 1, 8'h00, expWrite(0, 32'h00100513, 0)));
      tabA.push_back(mv(0, 0, 1, 8'h77, expLoad(1, 32'h0, 1)));
      tabA.push_back(mv(0, 0, 1, 8'h77, expLoad(1, 32'h00000077, 1)));
      tabA.push_back(mv(0, 0, 1, 8'h66, expLoad(1, 32'h00006677, 1)));
      tabA.push_back(mv(0, 0, 1, 8'h55, expLoad(1, 32'h00556677, 1)));
      tabA.push_back(mv(0, 0, 1, 8'h44, expWrite(1, 32'h44556677, 1)));
      tabA.push_back(mv(0, 0, 0, 8'h00, expLoad(2, 32'h0, 2)));
      tabA.push_back(mv(0, 1, 0, 8'h00, expDone(2, 2, 0)));
      tabA.push_back(mv(0, 1, 0, 8'h00, expDone(2, 2, 0)));
      tabA.push_back(mv(0, 0, 1, 8'h99, expDone(2, 2, 0)));
      tabA.push_back(mv(1, 0, 0, 8'h00, expLoad(0, 32'h0, 0)));
      tabA.push_back(mv(0, 0, 1, 8'hAA, expLoad(0, 32'h000000AA, 0)));
      tabA.push_back(mv(0, 1, 1, 8'hBB, expWrite(0, 32'h0000BBAA, 0)));
      tabA.push_back(mv(0, 0, 0, 8'h00, expDone(1, 1, 0)));
      tabA.push_back(mv(1, 0, 0, 8'h00, expLoad(0, 32'h0, 0)));
      tabA.push_back(mv(0, 1, 0, 8'h00, expDone(0, 0, 0)));
      tabA.push_back(mv(1, 0, 0, 8'h00, expLoad(0, 32'h0, 0)));
      tabA.push_back(mv(1, 0, 1, 8'h01, expLoad(0, 32'h00000001, 0)));
      tabA.push_back(mv(0, 1, 0, 8'h00, expWrite(0, 32'h00000001, 0)));
      tabA.push_back(mv(1, 0, 0, 8'h00, expDone(1, 1, 0)));
      tabA.push_back(mv(1, 0, 0, 8'h00, expLoad(0, 32'h0, 0)));
      tabA.push_back(mv(0, 0, 1, 8'h01, expLoad(0, 32'h00000001, 0)));
      tabA.push_back(mv(0, 0, 1, 8'h02, expLoad(0, 32'h00000201, 0)));
      tabA.push_back(mv(0, 0, 1, 8'h03, expLoad(0, 32'h00030201, 0)));
      tabA.push_back(mv(0, 1, 1, 8'h04, expWrite(0, 32'h04030201, 0)));
      tabA.push_back(mv(0, 0, 0, 8'h00, expDone(1, 1, 0)));

      // Two-word limit: the session ends on its own and a further byte flags overflow.
      tabB.push_back(mv(1, 0, 0, 8'h00, expLoad(0, 32'h0, 0)));
      tabB.push_back(mv(0, 0, 1, 8'h11, expLoad(0, 32'h00000011, 0)));
      tabB.push_back(mv(0, 0, 1, 8'h22, expLoad(0, 32'h00002211, 0)));
      tabB.push_back(mv(0, 0, 1, 8'h33, expLoad(0, 32'h00332211, 0)));
      tabB.push_back(mv(0, 0, 1, 8'h44, expWrite(0, 32'h44332211, 0)));
      tabB.push_back(mv(0, 0, 0, 8'h00, expLoad(1, 32'h0, 1)));
      tabB.push_back(mv(0, 0, 1, 8'h55, expLoad(1, 32'h00000055, 1)));
      tabB.push_back(mv(0, 0, 1, 8'h66, expLoad(1, 32'h00006655, 1)));
      tabB.push_back(mv(0, 0, 1, 8'h77, expLoad(1, 32'h00776655, 1)));
      tabB.push_back(mv(0, 0, 1, 8'h88, expWrite(1, 32'h88776655, 1)));
      tabB.push_back(mv(0, 0, 0, 8'h00, expDone(2, 2, 0)));
      tabB.push_back(mv(0, 0, 1, 8'h99, expDone(2, 2, 1)));
      tabB.push_back(mv(0, 0, 0, 8'h00, expDone(2, 2, 1)));
      tabB.push_back(mv(1, 0, 0, 8'h00, expLoad(0, 32'h0, 0)));

      repeat (2) @(posedge clk);
      #1;
      checkOutput(0, zero, "resetA");
      checkOutput(1, zero, "resetB");
      applyStimulus(0, 0, 0, 0, 8'h00, 0);
      checkOutput(0, zero, "idleA");

      foreach (tabA[i]) begin
         applyStimulus(0, tabA[i].st, tabA[i].fin, tabA[i].v, tabA[i].d, 0);
         checkOutput(0, tabA[i].exp, $sformatf("A[%0d]", i));
      end

      // Reset in the middle of a word discards the partial bytes.
      applyStimulus(0, 1, 0, 0, 8'h00, 0);
      checkOutput(0, expLoad(0, 32'h0, 0), "clrSeqStart");
      applyStimulus(0, 0, 0, 1, 8'hAA, 0);
      applyStimulus(0, 0, 0, 1, 8'hBB, 0);
      checkOutput(0, expLoad(0, 32'h0000BBAA, 0), "clrSeqTwoBytes");
      applyStimulus(0, 1, 1, 1, 8'hCC, 1);
      checkOutput(0, zero, "clrMidWord");
      applyStimulus(0, 0, 0, 0, 8'h00, 0);
      checkOutput(0, zero, "idleAfterClr");
      applyStimulus(0, 1, 0, 0, 8'h00, 0);
      applyStimulus(0, 0, 0, 1, 8'h01, 0);
      applyStimulus(0, 0, 0, 1, 8'h02, 0);
      applyStimulus(0, 0, 0, 1, 8'h03, 0);
      applyStimulus(0, 0, 0, 1, 8'h04, 0);
      checkOutput(0, expWrite(0, 32'h04030201, 0), "restartAddr0");

      // Reset during the write cycle itself.
      applyStimulus(0, 0, 0, 1, 8'h55, 1);
      checkOutput(0, zero, "clrMidWrite");
      applyStimulus(0, 0, 0, 0, 8'h00, 0);
      checkOutput(0, zero, "idleAfterClrWrite");

      foreach (tabB[i]) begin
         applyStimulus(1, tabB[i].st, tabB[i].fin, tabB[i].v, tabB[i].d, 0);
         checkOutput(1, tabB[i].exp, $sformatf("B[%0d]", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
